tb_ptr_writer: RTL
==================

# tb_ptr_writer

Writer side of the traceback-pointer memories used by the WFA traceback unit. Takes one wavefront of 4-bit traceback pointers per score from the wavefront compute stage through a valid/ready handshake. Serializes the pointers into the traceback-pointer BRAM at a running base offset, and records per-score Kmin and base offset ("width") into their BRAMs. The traceback reader then locates any entry as `diag - Kmin[score] + width[score]`.

## Interface
- MAX_WAVEFRONT_LEN, 32, max diagonals per wavefront
- LOG_MAX_WAVEFRONT_LEN, 5, log2 of above
- ADDR_WIDTH, 8, BRAM address width
- DATA_WIDTH, 8, Kmin/width BRAM data width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  arm for a new tile; clears base offset and flags
- wf_valid  in  1  wavefront offered
- wf_ready  out  1  writer can accept wavefront
- wf_score  in  LOG_MAX_WAVEFRONT_LEN  score of offered wavefront
- wf_kmin  in  DATA_WIDTH  lowest diagonal of wavefront (two's complement)
- wf_len  in  LOG_MAX_WAVEFRONT_LEN+1  number of diagonals, 0..MAX_WAVEFRONT_LEN
- wf_ptrs  in  4 x MAX_WAVEFRONT_LEN  pointer per diagonal; index 0 = Kmin
- wf_last  in  1  final wavefront of tile
- tb_ptr_we / tb_ptr_addr / tb_ptr_wdata  out  1 / ADDR_WIDTH / 4  pointer BRAM write port
- kmin_we / kmin_addr / kmin_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  Kmin BRAM write port, address = score
- width_we / width_addr / width_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  base-offset BRAM write port, address = score
- done  out  1  tile complete, sticky until start/rst
- overflow  out  1  sticky, pointer BRAM capacity exceeded
- err_order  out  1  sticky score-order error (0 when check compiled out)

## Operation
- States: IDLE, ACCEPT, HDR, BODY, DONE. Reset to IDLE.
- IDLE: wf_ready=0. start -> ACCEPT, base=0, flags cleared.
- ACCEPT: wf_ready=1. On wf_valid&&wf_ready, capture score, kmin, len (values >MAX_WAVEFRONT_LEN clamp to MAX), ptrs and last. Then go to HDR.
- HDR: if base+len > 2^ADDR_WIDTH (base held ADDR_WIDTH+1 bits wide), set overflow, write nothing, go to DONE. Otherwise assert kmin_we and width_we at addr=score, with kmin_wdata=kmin and width_wdata=base (zero-extended/truncated to DATA_WIDTH). Go to BODY, or finish directly if len=0.
- BODY: index i from 0 to len-1. One write per cycle: tb_ptr_addr=base+i, tb_ptr_wdata=ptrs[i]. Pointer codes are passed through unmodified.
- Finish (end of BODY or len=0 HDR): base += len. Go to DONE if last, else to ACCEPT.
- DONE: done=1, wf_ready=0. start -> ACCEPT with base and flags cleared.
- start is ignored in HDR and BODY.
- wf_ready depends only on state, never on wf_valid.

## Timing
- Reset values: wf_ready=0, all *_we=0, all addr/wdata=0, done=0, overflow=0, err_order=0, base=0.
- Write ports are registered outputs. The *_we pulse lasts exactly one cycle per write.
- Handshake at cycle t → HDR writes at t+1 → BODY writes at t+2..t+1+len → wf_ready=1 again at t+2+len (when not last).
- Throughput is one wavefront per len+2 cycles.
- Every output except the write ports is valid the cycle after the state change.
- rst during BODY: all we deassert at the next edge. No partial completion; base returns to 0.
- Simultaneous start and wf_valid in IDLE: only start takes effect. The wavefront is not accepted that cycle.

## Configuration
- TBW_SCORE_ORDER_CHECK_EN defined: wf_score must strictly exceed the previously accepted score in the tile (first wavefront of a tile is always legal).
  - A violating wavefront is still handshaken, but nothing is written for it and base is unchanged.
  - err_order sets (sticky). If that wavefront had wf_last=1, the FSM still goes to DONE.
- TBW_SCORE_ORDER_CHECK_EN undefined: no check; err_order tied 0.

## Structure
- Shared package tb_pkg holds:
  - tb_ptr_t (4-bit pointer type).
  - Pointer source codes: 00 = same diagonal, 01 = diag-1 (insertion), 10 = diag+1 (deletion), 11 = end.
  - Extend bits: bit2 = insertion extend, bit3 = deletion extend.
  - The writer state enum.
- One sub-module is natural: tbw_serializer. It holds the captured pointer vector and index i, and outputs the current pointer and the last-index flag.

## Test plan
- start, then one wavefront (score=0, kmin=0, len=1, ptrs[0]=4'b0011, last=1) -> kmin[0]=0, width[0]=0, tb_ptr[0]=3, done=1 three cycles after handshake.
- Wavefronts score 0 (kmin=0, len=1), 1 (kmin=-1, len=3), 2 (kmin=-2, len=5, last) -> width writes 0, 1, 4; kmin writes 0x00, 0xFF, 0xFE; pointers written to addresses 0..8 in order. Check the reader address for score=2, diag=1: 1-(-2)+4 = 7.
- ADDR_WIDTH=4, wavefronts of len 10 and then len 7 -> first wavefront written, second has no writes, overflow=1, done=1.
- len=0 wavefront mid-tile -> header written with current base, no tb_ptr_we pulses, next wavefront reuses the same base.
- Hold wf_valid low for 5 cycles in ACCEPT, then assert it; separately assert rst during BODY with len=8 -> no spurious writes while waiting; writes stop the cycle after rst and all outputs return to reset values.
- With TBW_SCORE_ORDER_CHECK_EN: scores 3 then 2 -> second wavefront produces no writes and err_order=1. Without the macro: both wavefronts are written and err_order=0.

Source files
------------

// File: rtl/tb_pkg.sv
// Shared types for the WFA traceback-pointer path: pointer encoding and writer FSM states.
package tb_pkg;

    typedef logic [3:0] tb_ptr_t;

    // Pointer bits [1:0] name the source diagonal of the cell.
    localparam logic [1:0] PTR_SRC_SAME = 2'b00;
    localparam logic [1:0] PTR_SRC_INS  = 2'b01;
    localparam logic [1:0] PTR_SRC_DEL  = 2'b10;
    localparam logic [1:0] PTR_SRC_END  = 2'b11;

    localparam int PTR_EXT_INS_BIT = 2;
    localparam int PTR_EXT_DEL_BIT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_HDR,
        ST_BODY,
        ST_DONE
    } tbw_state_e;

endpackage

// File: rtl/tbw_serializer.sv
// Holds one captured wavefront of pointers and hands them out one per advance, lowest diagonal first.
module tbw_serializer
    import tb_pkg::*;
#(
    parameter int MAX_WAVEFRONT_LEN     = 32,
    parameter int LOG_MAX_WAVEFRONT_LEN = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_i,
    input  logic                               adv_i,
    input  logic [4*MAX_WAVEFRONT_LEN-1:0]     ptrs_i,
    input  logic [LOG_MAX_WAVEFRONT_LEN:0]     len_i,
    output tb_ptr_t                            ptr_o,
    output logic                               last_o
);

    logic [4*MAX_WAVEFRONT_LEN-1:0] vec_q;
    logic [LOG_MAX_WAVEFRONT_LEN:0] idx_q;

    // The vector shifts down so the pointer to issue next always sits in the low nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            vec_q <= ptrs_i;
            idx_q <= '0;
        end else if (adv_i) begin
            vec_q <= vec_q >> 4;
            idx_q <= idx_q + (LOG_MAX_WAVEFRONT_LEN+1)'(1);
        end
    end

    assign ptr_o  = vec_q[3:0];
    assign last_o = (idx_q + (LOG_MAX_WAVEFRONT_LEN+1)'(1)) == len_i;

endmodule

// File: rtl/tb_ptr_writer.sv
// Traceback-pointer writer: serializes wavefronts into the pointer BRAM and logs Kmin/base per score.
// Optional build macro TBW_SCORE_ORDER_CHECK_EN enables the strictly-increasing score check.
module tb_ptr_writer
    import tb_pkg::*;
#(
    parameter int MAX_WAVEFRONT_LEN     = 32,
    parameter int LOG_MAX_WAVEFRONT_LEN = 5,
    parameter int ADDR_WIDTH            = 8,
    parameter int DATA_WIDTH            = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               wf_valid,
    output logic                               wf_ready,
    input  logic [LOG_MAX_WAVEFRONT_LEN-1:0]   wf_score,
    input  logic [DATA_WIDTH-1:0]              wf_kmin,
    input  logic [LOG_MAX_WAVEFRONT_LEN:0]     wf_len,
    input  logic [4*MAX_WAVEFRONT_LEN-1:0]     wf_ptrs,
    input  logic                               wf_last,
    output logic                               tb_ptr_we,
    output logic [ADDR_WIDTH-1:0]              tb_ptr_addr,
    output logic [3:0]                         tb_ptr_wdata,
    output logic                               kmin_we,
    output logic [ADDR_WIDTH-1:0]              kmin_addr,
    output logic [DATA_WIDTH-1:0]              kmin_wdata,
    output logic                               width_we,
    output logic [ADDR_WIDTH-1:0]              width_addr,
    output logic [DATA_WIDTH-1:0]              width_wdata,
    output logic                               done,
    output logic                               overflow,
    output logic                               err_order
);

    localparam int LW   = LOG_MAX_WAVEFRONT_LEN + 1;
    localparam int BW   = ADDR_WIDTH + 1;
    localparam int SUMW = ((BW > LW) ? BW : LW) + 1;

    tbw_state_e state_q, state_d;
    logic [BW-1:0]          base_q, base_d;
    logic [LW-1:0]          len_q, len_d, len_c;
    logic                   last_q, last_d;
    logic                   ovf_q, ovf_d, ord_q, ord_d;
    logic                   issued_last_q, issued_last_d;
    logic                   overflow_q, overflow_d;
    logic                   ptr_we_q, ptr_we_d, kmin_we_q, kmin_we_d, width_we_q, width_we_d;
    logic [ADDR_WIDTH-1:0]  ptr_addr_q, ptr_addr_d, hdr_addr_q, hdr_addr_d;
    tb_ptr_t                ptr_wdata_q, ptr_wdata_d;
    logic [DATA_WIDTH-1:0]  kmin_wdata_q, kmin_wdata_d, width_wdata_q, width_wdata_d;
    logic [SUMW-1:0]        need;
    logic                   len_ovf, order_bad, hs, arm;
    logic                   ser_load, ser_adv, ser_last;
    tb_ptr_t                ser_ptr;

    assign hs      = (state_q == ST_ACCEPT) && wf_valid;
    assign arm     = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign len_c   = (wf_len > LW'(MAX_WAVEFRONT_LEN)) ? LW'(MAX_WAVEFRONT_LEN) : wf_len;
    assign need    = SUMW'(base_q) + SUMW'(len_c);
    assign len_ovf = need > (SUMW'(1) << ADDR_WIDTH);

`ifdef TBW_SCORE_ORDER_CHECK_EN
    logic [LOG_MAX_WAVEFRONT_LEN-1:0] prev_score_q;
    logic                             have_prev_q;
    logic                             err_q;

    assign order_bad = have_prev_q && (wf_score <= prev_score_q);

    // Only legal wavefronts advance the score watermark.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_score_q <= '0;
            have_prev_q  <= 1'b0;
            err_q        <= 1'b0;
        end else if (arm) begin
            have_prev_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (hs && !order_bad) begin
                prev_score_q <= wf_score;
                have_prev_q  <= 1'b1;
            end
            if (state_q == ST_HDR && ord_q)
                err_q <= 1'b1;
        end
    end

    assign err_order = err_q;
`else
    assign order_bad = 1'b0;
    assign err_order = 1'b0;
`endif

    tbw_serializer #(
        .MAX_WAVEFRONT_LEN     (MAX_WAVEFRONT_LEN),
        .LOG_MAX_WAVEFRONT_LEN (LOG_MAX_WAVEFRONT_LEN)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load_i (ser_load),
        .adv_i  (ser_adv),
        .ptrs_i (wf_ptrs),
        .len_i  (len_q),
        .ptr_o  (ser_ptr),
        .last_o (ser_last)
    );

    // Write ports are loaded on the edge entering the state that owns them, so a
    // header write is visible during HDR and pointer writes during BODY.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        last_d        = last_q;
        ovf_d         = ovf_q;
        ord_d         = ord_q;
        issued_last_d = issued_last_q;
        overflow_d    = overflow_q;
        ptr_we_d      = 1'b0;
        kmin_we_d     = 1'b0;
        width_we_d    = 1'b0;
        ptr_addr_d    = ptr_addr_q;
        hdr_addr_d    = hdr_addr_q;
        ptr_wdata_d   = ptr_wdata_q;
        kmin_wdata_d  = kmin_wdata_q;
        width_wdata_d = width_wdata_q;
        ser_load      = 1'b0;
        ser_adv       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_ACCEPT;
                    base_d     = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (wf_valid) begin
                    state_d  = ST_HDR;
                    len_d    = len_c;
                    last_d   = wf_last;
                    ord_d    = order_bad;
                    ovf_d    = len_ovf && !order_bad;
                    ser_load = 1'b1;
                    if (!order_bad && !len_ovf) begin
                        kmin_we_d     = 1'b1;
                        width_we_d    = 1'b1;
                        hdr_addr_d    = ADDR_WIDTH'(wf_score);
                        kmin_wdata_d  = wf_kmin;
                        width_wdata_d = DATA_WIDTH'(base_q);
                    end
                end
            end
            ST_HDR: begin
                if (ovf_q) begin
                    overflow_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (ord_q || len_q == '0) begin
                    state_d = last_q ? ST_DONE : ST_ACCEPT;
                end else begin
                    state_d       = ST_BODY;
                    ptr_we_d      = 1'b1;
                    ptr_addr_d    = base_q[ADDR_WIDTH-1:0];
                    ptr_wdata_d   = ser_ptr;
                    issued_last_d = ser_last;
                    ser_adv       = 1'b1;
                end
            end
            ST_BODY: begin
                if (issued_last_q) begin
                    base_d  = base_q + BW'(len_q);
                    state_d = last_q ? ST_DONE : ST_ACCEPT;
                end else begin
                    ptr_we_d      = 1'b1;
                    ptr_addr_d    = ptr_addr_q + ADDR_WIDTH'(1);
                    ptr_wdata_d   = ser_ptr;
                    issued_last_d = ser_last;
                    ser_adv       = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            last_q        <= 1'b0;
            ovf_q         <= 1'b0;
            ord_q         <= 1'b0;
            issued_last_q <= 1'b0;
            overflow_q    <= 1'b0;
            ptr_we_q      <= 1'b0;
            kmin_we_q     <= 1'b0;
            width_we_q    <= 1'b0;
            ptr_addr_q    <= '0;
            hdr_addr_q    <= '0;
            ptr_wdata_q   <= '0;
            kmin_wdata_q  <= '0;
            width_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            last_q        <= last_d;
            ovf_q         <= ovf_d;
            ord_q         <= ord_d;
            issued_last_q <= issued_last_d;
            overflow_q    <= overflow_d;
            ptr_we_q      <= ptr_we_d;
            kmin_we_q     <= kmin_we_d;
            width_we_q    <= width_we_d;
            ptr_addr_q    <= ptr_addr_d;
            hdr_addr_q    <= hdr_addr_d;
            ptr_wdata_q   <= ptr_wdata_d;
            kmin_wdata_q  <= kmin_wdata_d;
            width_wdata_q <= width_wdata_d;
        end
    end

    assign wf_ready     = (state_q == ST_ACCEPT);
    assign done         = (state_q == ST_DONE);
    assign overflow     = overflow_q;
    assign tb_ptr_we    = ptr_we_q;
    assign tb_ptr_addr  = ptr_addr_q;
    assign tb_ptr_wdata = ptr_wdata_q;
    assign kmin_we      = kmin_we_q;
    assign kmin_addr    = hdr_addr_q;
    assign kmin_wdata   = kmin_wdata_q;
    assign width_we     = width_we_q;
    assign width_addr   = hdr_addr_q;
    assign width_wdata  = width_wdata_q;

endmodule
